// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared fp32 constants and drain FSM encoding
package systolic_pkg;
   localparam int          FP32_W        = 32;
   localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

   typedef enum logic {
      IDLE,
      ACCUM
   } drain_state_e;
endpackage

// File: rtl/fp32_add.sv
// rtl/fp32_add.sv - combinational fp32 adder (RNE, subnormals treated as zero) with PE passthroughs
module fp32_add
   import systolic_pkg::*;
(
   input  logic [FP32_W-1:0] a,
   input  logic [FP32_W-1:0] b,
   input  logic [FP32_W-1:0] x_i,
   input  logic [FP32_W-1:0] w_i,
   input  logic              valid_in,
   output logic [FP32_W-1:0] y,
   output logic [FP32_W-1:0] x_o,
   output logic [FP32_W-1:0] w_o,
   output logic              valid_out
);
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, big_s, sticky;
   logic [7:0]        big_e, sml_e, d;
   logic [23:0]       big_m, sml_m;
   logic [26:0]       big_ext, sml_ext, sml_sh, n;
   logic [27:0]       s;
   logic [4:0]        lz;
   logic [24:0]       r;
   logic [22:0]       frac;
   logic signed [9:0] e;
   logic [FP32_W-1:0] norm;

   assign x_o       = x_i;
   assign w_o       = w_i;
   assign valid_out = valid_in;

   always_comb begin
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      swap   = (b[30:0] > a[30:0]);
      big_s  = swap ? b[31] : a[31];
      big_e  = swap ? b[30:23] : a[30:23];
      sml_e  = swap ? a[30:23] : b[30:23];
      big_m  = swap ? {1'b1, b[22:0]} : {1'b1, a[22:0]};
      sml_m  = swap ? {1'b1, a[22:0]} : {1'b1, b[22:0]};
      d      = big_e - sml_e;

      // three extra bits (guard, round, sticky) below the 24-bit significand
      big_ext = {big_m, 3'b000};
      sml_ext = {sml_m, 3'b000};
      if (d > 8'd26) begin
         sml_sh = 27'd0;
         sticky = 1'b1;
      end else begin
         sml_sh = sml_ext >> d;
         sticky = |(sml_ext & ((27'd1 << d) - 27'd1));
      end
      sml_sh[0] = sml_sh[0] | sticky;

      if (a[31] ^ b[31]) s = {1'b0, big_ext} - {1'b0, sml_sh};
      else               s = {1'b0, big_ext} + {1'b0, sml_sh};

      e  = $signed({2'b00, big_e});
      lz = 5'd0;
      for (int i = 0; i <= 26; i++) begin
         if (s[i]) lz = 5'(26 - i);
      end
      if (s[27]) begin
         n    = s[27:1];
         n[0] = s[1] | s[0];
         e    = e + 10'sd1;
      end else begin
         n = s[26:0] << lz;
         e = e - $signed({5'd0, lz});
      end

      r    = {1'b0, n[26:3]} + 25'(n[2] & (n[3] | n[1] | n[0]));
      frac = r[24] ? 23'd0 : r[22:0];
      if (r[24]) e = e + 10'sd1;

      if (s == 28'd0)         norm = FP32_POS_ZERO;
      else if (e >= 10'sd255) norm = {big_s, 8'hFF, 23'd0};
      else if (e <= 10'sd0)   norm = {big_s, 31'd0};
      else                    norm = {big_s, e[7:0], frac};

      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = FP32_QNAN;
      else if (a_inf)            y = a;
      else if (b_inf)            y = b;
      else if (a_zero && b_zero) y = {a[31] & b[31], 31'd0};
      else if (a_zero)           y = b;
      else if (b_zero)           y = a;
      else                       y = norm;
   end
endmodule

// File: rtl/fp32_sync_fifo.sv
// rtl/fp32_sync_fifo.sv - first-word-fall-through FIFO; a pop frees a slot for a same-cycle push
module fp32_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
         else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/fp32_psum_drain.sv
// rtl/fp32_psum_drain.sv - accumulates TILE_K column partial sums and queues results for writeback
module fp32_psum_drain
   import systolic_pkg::*;
#(
   parameter int TILE_K     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [FP32_W-1:0] y_in,
   input  logic              flush,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [FP32_W-1:0] m_data,
   output logic              overflow,
   output logic              busy
);
   localparam int               CNT_W = $clog2(TILE_K + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TILE_K - 1);

   drain_state_e      state, state_next;
   logic [FP32_W-1:0] acc, acc_next, sum, push_data;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              push, pop, full, empty;
   logic [FP32_W-1:0] unused_x, unused_w;
   logic              unused_v;

   fp32_add u_add (
      .a         (acc),
      .b         (y_in),
      .x_i       ('0),
      .w_i       ('0),
      .valid_in  (1'b1),
      .y         (sum),
      .x_o       (unused_x),
      .w_o       (unused_w),
      .valid_out (unused_v)
   );

   fp32_sync_fifo #(.WIDTH(FP32_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (m_data),
      .full  (full),
      .empty (empty)
   );

   assign m_valid = ~empty;
   assign pop     = m_valid & m_ready;
   assign busy    = (state == ACCUM) | ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= FP32_POS_ZERO;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            // first sample is loaded as-is so -0 and NaN payloads survive
            if (valid_in && !flush && TILE_K > 1) begin
               acc_next   = y_in;
               cnt_next   = CNT_W'(1);
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (valid_in && !flush && cnt != LAST) begin
               acc_next = sum;
               cnt_next = cnt + CNT_W'(1);
            end else if (valid_in || flush) begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      push_data = sum;
      case (state)
         IDLE: begin
            if (valid_in && (flush || TILE_K == 1)) begin
               push      = 1'b1;
               push_data = y_in;
            end
         end
         ACCUM: begin
            if (valid_in && (flush || cnt == LAST)) begin
               push = 1'b1;
            end else if (flush && !valid_in) begin
               push      = 1'b1;
               push_data = acc;
            end
         end
         default: push = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_fp32_psum_drain.sv
// tb/tb_fp32_psum_drain.sv - directed bench with a queue-level real-arithmetic reference model
module tb_fp32_psum_drain;
   localparam int TILE_K     = 4;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n, valid_in, flush, m_ready;
   logic [31:0] y_in;
   logic        m_valid, overflow, busy;
   logic [31:0] m_data;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] grp[$];
   logic [31:0] q[$];
   logic        ovf;

   fp32_psum_drain #(.TILE_K(TILE_K), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .y_in     (y_in),
      .flush    (flush),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
   endtask

   function automatic real bits2real(input logic [31:0] b);
      int  e;
      real v;
      e = int'(b[30:23]);
      if (e == 0) return 0.0;
      v = 1.0 + real'(b[22:0]) / 8388608.0;
      for (int k = 0; k < e - 127; k++) v = v * 2.0;
      for (int k = 0; k < 127 - e; k++) v = v / 2.0;
      return b[31] ? -v : v;
   endfunction

   function automatic logic [31:0] real2bits(input real r);
      logic   s;
      real    m, f, fi;
      int     e, be;
      longint mant;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      f    = (m - 1.0) * 8388608.0;
      fi   = $floor(f);
      mant = longint'(fi);
      if ((f - fi) > 0.5 || ((f - fi) == 0.5 && mant[0])) mant++;
      if (mant == 64'd8388608) begin mant = 0; e++; end
      be = e + 127;
      if (be >= 255) return {s, 8'hFF, 23'd0};
      if (be <= 0)   return {s, 31'd0};
      return {s, be[7:0], mant[22:0]};
   endfunction

   // IEEE single add via double precision: one exact-enough sum then one RNE to 24 bits
   function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
      logic an, bn, ai, bi, az, bz;
      real  r;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      az = (a[30:23] == 8'h00);
      bz = (b[30:23] == 8'h00);
      if (an || bn || (ai && bi && a[31] != b[31])) return 32'h7FC0_0000;
      if (ai) return a;
      if (bi) return b;
      if (az && bz) return {a[31] & b[31], 31'd0};
      if (az) return b;
      if (bz) return a;
      r = bits2real(a) + bits2real(b);
      if (r == 0.0) return 32'h0;
      return real2bits(r);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [31:0] res;
      if (!rst_n) begin
         grp.delete();
         q.delete();
         ovf = 1'b0;
      end else begin
         if (q.size() > 0 && m_ready) void'(q.pop_front());
         if (valid_in) grp.push_back(y_in);
         if (grp.size() == TILE_K || (flush && grp.size() > 0)) begin
            res = grp[0];
            for (int i = 1; i < grp.size(); i++) res = model_add(res, grp[i]);
            grp.delete();
            if (q.size() < FIFO_DEPTH) q.push_back(res);
            else ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
      chk("m_data", m_data, (q.size() > 0) ? q[0] : 32'h0);
      chk("overflow", 32'(overflow), 32'(ovf));
      chk("busy", 32'(busy), 32'(grp.size() > 0 || q.size() > 0));
   end

   task automatic step(input logic v, input logic [31:0] y, input logic f);
      valid_in = v;
      y_in     = y;
      flush    = f;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   logic [31:0] one_to_four [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
   logic [31:0] grp_res     [5] = '{32'h4080_0000, 32'h4100_0000, 32'h4140_0000, 32'h4180_0000, 32'h41A0_0000};

   task automatic fill_groups(input int first, input int ngrp);
      for (int g = first; g < first + ngrp; g++)
         for (int k = 0; k < TILE_K; k++) step(1'b1, real2bits(real'(g + 1)), 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; y_in = 32'h0; flush = 1'b0; m_ready = 1'b1;

      chk("model_1p2", model_add(32'h3F80_0000, 32'h4000_0000), 32'h4040_0000);
      chk("model_inf_ninf", model_add(32'h7F80_0000, 32'hFF80_0000), 32'h7FC0_0000);
      chk("model_cancel", model_add(32'h3F80_0000, 32'hBF80_0000), 32'h0000_0000);
      chk("model_1p5_2p5", model_add(32'h3FC0_0000, 32'h4020_0000), 32'h4080_0000);
      chk("model_rne_tie", model_add(32'h3F80_0000, 32'h3380_0000), 32'h3F80_0000);
      chk("model_rne_up", model_add(32'h3F80_0000, 32'h3380_0001), 32'h3F80_0001);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'h0);
      chk("rst_m_data", m_data, 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      idle(1);

      // sum of 1..4, result visible the cycle after the last sample
      for (int k = 0; k < 4; k++) step(1'b1, one_to_four[k], 1'b0);
      chk("t1_valid", 32'(m_valid), 32'h1);
      chk("t1_data", m_data, 32'h4120_0000);
      idle(2);

      step(1'b1, 32'h7F80_0000, 1'b0);
      step(1'b1, 32'hFF80_0000, 1'b0);
      step(1'b1, 32'h3F80_0000, 1'b0);
      step(1'b1, 32'h3F80_0000, 1'b0);
      chk("t2_nan", m_data, 32'h7FC0_0000);
      idle(2);

      step(1'b1, 32'h3FC0_0000, 1'b0);
      step(1'b1, 32'h4020_0000, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      chk("t3_flush", m_data, 32'h4080_0000);
      idle(1);
      chk("t3_idle", 32'(busy), 32'h0);
      step(1'b1, 32'h3FC0_0000, 1'b0);
      step(1'b1, 32'h4020_0000, 1'b1);
      chk("t3_flush_with_sample", m_data, 32'h4080_0000);
      idle(2);

      step(1'b1, 32'h8000_0000, 1'b1);
      chk("neg_zero_single", m_data, 32'h8000_0000);
      step(1'b0, 32'h0, 1'b1);
      chk("idle_flush_noop", 32'(m_valid), 32'h0);
      step(1'b1, 32'h3F80_0000, 1'b0);
      step(1'b1, 32'h3380_0000, 1'b1);
      chk("rne_tie_dut", m_data, 32'h3F80_0000);
      step(1'b1, 32'h3F80_0000, 1'b0);
      step(1'b1, 32'hBF80_0000, 1'b0);
      step(1'b1, 32'h0000_0000, 1'b0);
      step(1'b1, 32'h0000_0000, 1'b0);
      chk("cancel_valid", 32'(m_valid), 32'h1);
      chk("cancel_data", m_data, 32'h0000_0000);
      idle(2);

      // backpressure: four queued results, fifth dropped
      m_ready = 1'b0;
      fill_groups(0, 4);
      chk("t4_full_head", m_data, grp_res[0]);
      chk("t4_no_ovf_yet", 32'(overflow), 32'h0);
      fill_groups(4, 1);
      chk("t4_overflow", 32'(overflow), 32'h1);
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_drain", m_data, grp_res[i]);
         idle(1);
      end
      chk("t4_empty", 32'(m_valid), 32'h0);

      // reset mid-group with a queued result and sticky overflow
      m_ready = 1'b0;
      fill_groups(0, 1);
      step(1'b1, 32'h3F80_0000, 1'b0);
      step(1'b1, 32'h4000_0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(m_valid), 32'h0);
      chk("t6_data", m_data, 32'h0);
      chk("t6_overflow", 32'(overflow), 32'h0);
      chk("t6_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b1, one_to_four[k], 1'b0);
      chk("t6_fresh", m_data, 32'h4120_0000);
      idle(2);

      // full FIFO, completing group and pop on the same edge
      do_reset();
      m_ready = 1'b0;
      fill_groups(0, 4);
      for (int k = 0; k < 3; k++) step(1'b1, 32'h40A0_0000, 1'b0);
      m_ready = 1'b1;
      step(1'b1, 32'h40A0_0000, 1'b0);
      chk("t5_no_ovf", 32'(overflow), 32'h0);
      for (int i = 1; i < 5; i++) begin
         chk("t5_drain", m_data, grp_res[i]);
         idle(1);
      end
      chk("t5_empty", 32'(m_valid), 32'h0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
